// File: rtl/sub8_rr_scheduler.sv
// sub8_rr_scheduler: round-robin time-sharing of a single 8-bit modular subtractor
module sub8_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_diff,
    output logic              rsp_borrow
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q, op_id_q, rsp_id_q, win, cand;
    logic [7:0]     op_a_q, op_b_q, rsp_diff_q;
    logic           rsp_valid_q, rsp_borrow_q, found;
    logic [8:0]     sub_d;
    // Cyclic search for the first active requester after the previous winner
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end
    // Grant only while idle; a held reset also masks the grant
    assign req_ready = (state_q == IDLE && found && !rst) ? NREQ'(1) << win : '0;
    // The one shared subtractor: bit 8 of the 9-bit difference is the borrow (a < b)
    assign sub_d = {1'b0, op_a_q} - {1'b0, op_b_q};
    // Accept, compute and hold-until-handshake sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDW'(NREQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_diff_q   <= '0;
            rsp_borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    op_a_q   <= req_a[8*win +: 8];
                    op_b_q   <= req_b[8*win +: 8];
                    op_id_q  <= win;
                    rr_ptr_q <= win;
                    state_q  <= CALC;
                end
                CALC: begin
                    rsp_diff_q   <= sub_d[7:0];
                    rsp_borrow_q <= sub_d[8];
                    rsp_id_q     <= op_id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_diff   = rsp_diff_q;
    assign rsp_borrow = rsp_borrow_q;
endmodule

// File: tb/tb_sub8_rr_scheduler.sv
// tb_sub8_rr_scheduler: vector table, directed corner sequences and a modelled random soak
module tb_sub8_rr_scheduler;
    localparam int NREQ = 4;
    logic            clk = 1'b0, rst = 1'b0;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [31:0]     req_a = '0, req_b = '0;
    logic            rsp_valid, rsp_ready = 1'b0, rsp_borrow;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_diff;
    int checks = 0, failures = 0;

    sub8_rr_scheduler #(.NREQ(NREQ), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_diff(rsp_diff), .rsp_borrow(rsp_borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a, b, diff;
        logic       borrow;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int diff8(input int a, input int b);
        return (a - b + 256) % 256;
    endfunction

    function automatic int pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic wait_rsp(input string nm);
        bit ok = 0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = rsp_valid;
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_diff", rsp_diff, 0);
        chk("rst_rsp_borrow", rsp_borrow, 0);
        chk("rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    bit [NREQ-1:0] pend = '0;
    logic [7:0] pa[NREQ], pb[NREQ], ea, eb;
    int issued[NREQ], got[NREQ];
    int last, age, ops, cyc, w, exp_id;
    bit busy;

    initial begin
        vecs[0] = '{0, 8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{2, 8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{2, 8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[3] = '{2, 8'h80, 8'h80, 8'h00, 1'b0};
        vecs[4] = '{1, 8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[5] = '{3, 8'h10, 8'h20, 8'hF0, 1'b1};
        #2 rst = 1'b1;
        req_valid = '1;
        do_reset();
        req_valid = '0;

        // single-requester operations from the table
        foreach (vecs[n]) begin
            @(negedge clk);
            req_valid = NREQ'(1) << vecs[n].id;
            set_ops(vecs[n].id, vecs[n].a, vecs[n].b);
            rsp_ready = 1'b1;
            #1 chk("vec_grant", req_ready, 1 << vecs[n].id);
            @(negedge clk);
            req_valid = '0;
            #1 chk("vec_calc_valid", rsp_valid, 0);
            chk("vec_calc_ready", req_ready, 0);
            @(negedge clk);
            #1 chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_id", rsp_id, vecs[n].id);
            chk("vec_rsp_diff", rsp_diff, vecs[n].diff);
            chk("vec_rsp_borrow", rsp_borrow, vecs[n].borrow);
        end

        // fairness: all requesters held active from reset
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(16 * i + 3), 8'(33 * i));
        do_reset();
        rsp_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            wait_rsp("fair");
            chk("fair_id", rsp_id, r % NREQ);
            chk("fair_diff", rsp_diff, diff8(16 * (r % NREQ) + 3, 33 * (r % NREQ)));
            chk("fair_borrow", rsp_borrow, (16 * (r % NREQ) + 3) < 33 * (r % NREQ));
        end
        req_valid = '0;

        // back-pressure: result held for five cycles, others waiting
        @(negedge clk);
        req_valid = 4'b0001;
        set_ops(0, 8'h55, 8'h22);
        rsp_ready = 1'b0;
        wait_rsp("bp");
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_diff", rsp_diff, 8'h33);
            chk("bp_ready", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp_release_valid", rsp_valid, 1);
        @(negedge clk);
        #1 chk("bp_idle_valid", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        wait_rsp("bp_next");
        chk("bp_next_id", rsp_id, 1);
        chk("bp_next_diff", rsp_diff, diff8(19, 33));

        // reset during CALC, then during RESP
        @(negedge clk);
        req_valid = 4'b0100;
        #1 chk("mid_grant", req_ready, 4'b0100);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("mid_calc_valid", rsp_valid, 0);
        chk("mid_calc_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0101;
        #1 chk("mid_prio", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        wait_rsp("mid");
        chk("mid_id", rsp_id, 0);
        #1 rst = 1'b1;
        #1 chk("mid_resp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // random soak against a transaction-level model
        last = NREQ - 1; busy = 0; age = 0; ops = 0; cyc = 0; exp_id = 0; ea = 0; eb = 0;
        for (int i = 0; i < NREQ; i++) begin
            issued[i] = 0;
            got[i] = 0;
        end
        while (ops < 10000 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i] = 8'($urandom);
                    pb[i] = 8'($urandom);
                end
                req_valid[i] = pend[i];
                if (pend[i]) set_ops(i, pa[i], pb[i]);
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            #1;
            if (busy) age++;
            chk("soak_rsp_valid", rsp_valid, busy && age >= 2);
            if (busy && age >= 2 && rsp_valid) begin
                chk("soak_id", rsp_id, exp_id);
                chk("soak_diff", rsp_diff, diff8(ea, eb));
                chk("soak_borrow", rsp_borrow, ea < eb);
            end
            w = busy ? -1 : pick(last, pend);
            chk("soak_req_ready", req_ready, w < 0 ? 0 : 1 << w);
            chk("soak_onehot", $countones(req_ready) <= 1, 1);
            if (rsp_valid && rsp_ready) got[rsp_id]++;
            if (busy && age >= 2 && rsp_ready) begin
                busy = 0;
                ops++;
            end else if (w >= 0) begin
                busy = 1;
                age = 0;
                last = w;
                exp_id = w;
                ea = pa[w];
                eb = pb[w];
                pend[w] = 1'b0;
                issued[w]++;
            end
        end
        if (ops < 10000) chk("soak_timeout", ops, 10000);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < NREQ; i++) chk("soak_count", got[i], issued[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
